// File: rtl/aidc_lite_bf16_comp.sv
// FP32 -> BF16 block compressor: 16x64b byte-enabled input buffer, 16-cycle
// conversion, 16x32b show-ahead output port drained by the compression engine.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   buf_wren_i      input buffer write enable
//   buf_waddr_i     input buffer entry index (0..15)
//   buf_wbe_i       byte enables, bit n covers buf_wdata_i[8n+7:8n]
//   buf_wdata_i     entry k = {fp32 word 2k, fp32 word 2k+1}
//   comp_start_i    start pulse, accepted only when idle
//   comp_ready_o    compressed block available
//   comp_rden_i     pop current output word, honored only when ready
//   comp_rdata_o    current output word (show-ahead)
module aidc_lite_bf16_comp #(
   parameter bit ROUND_RNE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        buf_wren_i,
   input  logic [3:0]  buf_waddr_i,
   input  logic [7:0]  buf_wbe_i,
   input  logic [63:0] buf_wdata_i,
   input  logic        comp_start_i,
   output logic        comp_ready_o,
   input  logic        comp_rden_i,
   output logic [31:0] comp_rdata_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CONV  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [63:0] buf_q [16];
   logic [31:0] out_q [16];
   logic [1:0]  state_q;
   logic [3:0]  cidx_q;
   logic [3:0]  rd_ptr_q;
   logic [63:0] entry;
   logic [31:0] conv_word;

   // NaNs are quieted and never rounded, so a NaN payload cannot
   // carry into the sign bit or collapse into Inf.
   function automatic logic [15:0] bf16(input logic [31:0] x);
      logic [15:0] u;
      logic [15:0] l;
      logic        inc;
      u   = x[31:16];
      l   = x[15:0];
      inc = (l > 16'h8000) || ((l == 16'h8000) && u[0]);
      if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0))
         bf16 = u | 16'h0040;
      else if (!ROUND_RNE)
         bf16 = u;
      else
         bf16 = u + {15'd0, inc};
   endfunction

   always_ff @(posedge clk) begin
      if (buf_wren_i) begin
         for (int n = 0; n < 8; n++) begin
            if (buf_wbe_i[n])
               buf_q[buf_waddr_i][8*n +: 8] <= buf_wdata_i[8*n +: 8];
         end
      end
   end

   assign entry     = buf_q[cidx_q];
   assign conv_word = {bf16(entry[63:32]), bf16(entry[31:0])};

   always_ff @(posedge clk) begin
      if (state_q == S_CONV)
         out_q[cidx_q] <= conv_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cidx_q   <= 4'd0;
         rd_ptr_q <= 4'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (comp_start_i) begin
                  state_q <= S_CONV;
                  cidx_q  <= 4'd0;
               end
            end
            S_CONV: begin
               cidx_q <= cidx_q + 4'd1;
               if (cidx_q == 4'd15) begin
                  state_q  <= S_READY;
                  rd_ptr_q <= 4'd0;
               end
            end
            S_READY: begin
               if (comp_rden_i) begin
                  rd_ptr_q <= rd_ptr_q + 4'd1;
                  if (rd_ptr_q == 4'd15)
                     state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign comp_ready_o = (state_q == S_READY);
   assign comp_rdata_o = out_q[rd_ptr_q];

endmodule

// File: tb/tb_aidc_lite_bf16_comp.sv
// Testbench for aidc_lite_bf16_comp: RNE and truncating instances share
// stimulus; expected words are queued at start and compared on drain.
module tb_aidc_lite_bf16_comp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        buf_wren = 1'b0;
   logic [3:0]  buf_waddr = 4'd0;
   logic [7:0]  buf_wbe = 8'd0;
   logic [63:0] buf_wdata = 64'd0;
   logic        comp_start = 1'b0;
   logic        comp_rden = 1'b0;
   logic        comp_ready;
   logic        comp_ready_t;
   logic [31:0] comp_rdata;
   logic [31:0] comp_rdata_t;

   int total = 0;
   int bad = 0;

   logic [63:0] mem_m [16];
   logic [31:0] q [$];
   logic [31:0] qt [$];
   logic [31:0] got [16];
   logic [31:0] got_t [16];

   always #5 clk = ~clk;

   aidc_lite_bf16_comp #(.ROUND_RNE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .buf_wren_i(buf_wren), .buf_waddr_i(buf_waddr),
      .buf_wbe_i(buf_wbe), .buf_wdata_i(buf_wdata),
      .comp_start_i(comp_start), .comp_ready_o(comp_ready),
      .comp_rden_i(comp_rden), .comp_rdata_o(comp_rdata)
   );

   aidc_lite_bf16_comp #(.ROUND_RNE(1'b0)) dut_t (
      .clk(clk), .rst_n(rst_n),
      .buf_wren_i(buf_wren), .buf_waddr_i(buf_waddr),
      .buf_wbe_i(buf_wbe), .buf_wdata_i(buf_wdata),
      .comp_start_i(comp_start), .comp_ready_o(comp_ready_t),
      .comp_rden_i(comp_rden), .comp_rdata_o(comp_rdata_t)
   );

   // Classic add-bias rounding, independent of the compare-based form.
   function automatic logic [15:0] ref_bf16(input logic [31:0] x, input bit rne);
      logic [31:0] r;
      if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0))
         return x[31:16] | 16'h0040;
      if (!rne)
         return x[31:16];
      r = x + 32'h0000_7FFF + {31'd0, x[16]};
      return r[31:16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
      buf_wren = 1'b1;
      buf_waddr = a;
      buf_wdata = d;
      buf_wbe = be;
      tick();
      buf_wren = 1'b0;
      buf_wbe = 8'd0;
      for (int n = 0; n < 8; n++)
         if (be[n]) mem_m[a][8*n +: 8] = d[8*n +: 8];
   endtask

   task automatic fill_random();
      for (int k = 0; k < 16; k++)
         wr(k[3:0], {$urandom, $urandom}, 8'hFF);
   endtask

   task automatic start_conv(input bit noise);
      int lat;
      for (int k = 0; k < 16; k++) begin
         q.push_back({ref_bf16(mem_m[k][63:32], 1'b1), ref_bf16(mem_m[k][31:0], 1'b1)});
         qt.push_back({ref_bf16(mem_m[k][63:32], 1'b0), ref_bf16(mem_m[k][31:0], 1'b0)});
      end
      comp_start = 1'b1;
      tick();
      comp_start = 1'b0;
      lat = 1;
      while (!comp_ready && lat < 40) begin
         if (noise) begin
            comp_start = 1'($urandom % 2);
            comp_rden = 1'($urandom % 2);
         end
         tick();
         lat++;
      end
      comp_start = 1'b0;
      comp_rden = 1'b0;
      total++;
      if (lat !== 17) begin
         bad++;
         $display("FAIL latency: got %0d cycles, want 17", lat);
      end
   endtask

   task automatic drain(input int gap_max, input bit noise, input bit last_start);
      logic [31:0] e;
      logic [31:0] et;
      for (int i = 0; i < 16; i++) begin
         if (q.size() == 0 || qt.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: queue empty at pop %0d", i);
            return;
         end
         e = q[0];
         et = qt[0];
         repeat ($urandom_range(0, gap_max)) begin
            if (noise) comp_start = 1'($urandom % 2);
            total++;
            if (comp_ready !== 1'b1 || comp_rdata !== e || comp_rdata_t !== et) begin
               bad++;
               $display("FAIL hold w%0d: rdy=%b d=%h dt=%h want %h %h",
                        i, comp_ready, comp_rdata, comp_rdata_t, e, et);
            end
            tick();
         end
         comp_start = (i == 15) ? last_start : 1'b0;
         total++;
         if (comp_ready !== 1'b1 || comp_rdata !== e || comp_rdata_t !== et) begin
            bad++;
            $display("FAIL pop w%0d: rdy=%b d=%h dt=%h want %h %h",
                     i, comp_ready, comp_rdata, comp_rdata_t, e, et);
         end
         got[i] = comp_rdata;
         got_t[i] = comp_rdata_t;
         comp_rden = 1'b1;
         tick();
         comp_rden = 1'b0;
         comp_start = 1'b0;
         void'(q.pop_front());
         void'(qt.pop_front());
      end
      total++;
      if (comp_ready !== 1'b0 || comp_ready_t !== 1'b0) begin
         bad++;
         $display("FAIL ready_drop: rdy=%b rdy_t=%b want 0", comp_ready, comp_ready_t);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if (comp_ready !== 1'b0 || comp_ready_t !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: got %b/%b want 0", comp_ready, comp_ready_t);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (comp_ready !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready: got %b want 0", comp_ready);
      end
   endtask

   task automatic test_all_ones();
      for (int k = 0; k < 16; k++)
         wr(k[3:0], 64'h3F800000_3F800000, 8'hFF);
      start_conv(1'b0);
      drain(0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         total++;
         if (got[k] !== 32'h3F803F80) begin
            bad++;
            $display("FAIL ones w%0d: got %h want 3f803f80", k, got[k]);
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] rne [5];
      logic [31:0] trn [5];
      rne = '{32'h3F803F82, 32'h3F817F80, 32'hBF810000, 32'h7FC0FF80, 32'hFFC18000};
      trn = '{32'h3F803F81, 32'h3F807F7F, 32'hBF800000, 32'h7FC0FF80, 32'hFFC18000};
      fill_random();
      wr(4'd0, 64'h3F808000_3F818000, 8'hFF);
      wr(4'd1, 64'h3F808001_7F7FFFFF, 8'hFF);
      wr(4'd2, 64'hBF80FFFF_00008000, 8'hFF);
      wr(4'd3, 64'h7F800001_FF800000, 8'hFF);
      wr(4'd4, 64'hFFC12345_80000000, 8'hFF);
      start_conv(1'b0);
      drain(1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (got[k] !== rne[k] || got_t[k] !== trn[k]) begin
            bad++;
            $display("FAIL round w%0d: got %h/%h want %h/%h", k, got[k], got_t[k], rne[k], trn[k]);
         end
      end
   endtask

   task automatic test_byte_enable();
      wr(4'd3, 64'h11111111_22222222, 8'hFF);
      wr(4'd3, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
      start_conv(1'b0);
      drain(0, 1'b0, 1'b0);
      // 0xBBBBBBBB is negative; low half 0xBBBB > 0x8000 rounds up.
      total++;
      if (got[3] !== 32'h1111BBBC || got_t[3] !== 32'h1111BBBB) begin
         bad++;
         $display("FAIL byte_en: got %h/%h want 1111bbbc/1111bbbb", got[3], got_t[3]);
      end
   endtask

   task automatic test_handshake();
      fill_random();
      start_conv(1'b1);
      drain(5, 1'b1, 1'b1);
      fill_random();
      start_conv(1'b0);
      drain(3, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_conv();
      fill_random();
      start_conv_abort();
      rst_n = 1'b0;
      comp_rden = 1'b1;
      tick();
      rst_n = 1'b1;
      q.delete();
      qt.delete();
      repeat (4) begin
         total++;
         if (comp_ready !== 1'b0 || comp_ready_t !== 1'b0) begin
            bad++;
            $display("FAIL rst_conv: rdy=%b/%b want 0", comp_ready, comp_ready_t);
         end
         tick();
      end
      comp_rden = 1'b0;
      start_conv(1'b0);
      drain(2, 1'b0, 1'b0);
   endtask

   task automatic start_conv_abort();
      comp_start = 1'b1;
      tick();
      comp_start = 1'b0;
      repeat (7) tick();
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_rounding();
      test_byte_enable();
      test_handshake();
      test_reset_mid_conv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
